// File: rtl/cache_ctrl_wb_param.sv
// Direct-mapped write-back / write-allocate cache controller with byte
// enables, parametrised geometry and saturating hit/miss counters.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   cpu_req_valid/rw/addr/data/be, cpu_req_ready
//                               CPU request channel; ready only in IDLE
//   cpu_res_data, cpu_res_ready registered read data and 1-cycle done pulse
//   mem_req_valid/rw/addr/data  line request to memory (rw=1 write-back)
//   mem_data_ready, mem_data    memory completion and refill line
//   hit_count, miss_count       saturating statistics counters
module cache_ctrl_wb_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LINE_W  = 128,
    parameter int INDEX_W = 10,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    input  logic                cpu_req_rw,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W-1:0]   cpu_req_data,
    input  logic [DATA_W/8-1:0] cpu_req_be,
    output logic                cpu_req_ready,
    output logic [DATA_W-1:0]   cpu_res_data,
    output logic                cpu_res_ready,
    output logic                mem_req_valid,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [LINE_W-1:0]   mem_req_data,
    input  logic                mem_data_ready,
    input  logic [LINE_W-1:0]   mem_data,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int OFFSET_W   = $clog2(LINE_W / 8);
    localparam int WORD_SEL_W = $clog2(LINE_W / DATA_W);
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BE_W       = DATA_W / 8;
    localparam int LINES      = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_refill;
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [TAG_W-1:0]    r_tags  [LINES];
    logic [LINE_W-1:0]   r_lines [LINES];
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic                r_res_ready;
    logic [DATA_W-1:0]   r_res_data;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_W-1:0]    w_index;
    logic [WORD_SEL_W-1:0] w_word;
    logic [TAG_W-1:0]      w_stored_tag;
    logic [LINE_W-1:0]     w_line;
    logic [LINE_W-1:0]     w_merged;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_hit;

    assign w_tag        = r_addr[ADDR_W-1 -: TAG_W];
    assign w_index      = r_addr[OFFSET_W +: INDEX_W];
    assign w_word       = r_addr[OFFSET_W-1 -: WORD_SEL_W];
    assign w_stored_tag = r_tags[w_index];
    assign w_line       = r_lines[w_index];
    assign w_hit        = r_valid[w_index] && (w_stored_tag == w_tag);
    assign w_rd_word    = w_line[int'(w_word)*DATA_W +: DATA_W];

    // Byte-enable merge of the latched write word into the current line.
    always_comb begin
        w_merged = w_line;
        for (int b = 0; b < BE_W; b++) begin
            if (r_be[b]) begin
                w_merged[int'(w_word)*DATA_W + b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:       if (cpu_req_valid) w_next = COMPARE;
            COMPARE: begin
                if (w_hit)
                    w_next = IDLE;
                else if (r_valid[w_index] && r_dirty[w_index])
                    w_next = WRITE_BACK;
                else
                    w_next = ALLOCATE;
            end
            WRITE_BACK: if (mem_data_ready) w_next = ALLOCATE;
            ALLOCATE:   if (mem_data_ready) w_next = COMPARE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready = (r_state == IDLE);
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        unique case (r_state)
            WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {w_stored_tag, w_index, {OFFSET_W{1'b0}}};
                mem_req_data  = w_line;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {w_tag, w_index, {OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

    // Control state, valid/dirty bits, response and statistics.
    // r_refill marks the re-compare after a refill so it is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_refill    <= 1'b0;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_res_ready <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_res_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        r_rw     <= cpu_req_rw;
                        r_addr   <= cpu_req_addr;
                        r_wdata  <= cpu_req_data;
                        r_be     <= cpu_req_be;
                        r_refill <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        r_res_ready <= 1'b1;
                        if (r_rw)
                            r_dirty[w_index] <= 1'b1;
                        else
                            r_res_data <= w_rd_word;
                    end
                    if (!r_refill) begin
                        if (w_hit) begin
                            if (r_hit_cnt != {CNT_W{1'b1}})
                                r_hit_cnt <= r_hit_cnt + 1'b1;
                        end else begin
                            if (r_miss_cnt != {CNT_W{1'b1}})
                                r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                end
                ALLOCATE: begin
                    if (mem_data_ready) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_refill         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (r_state == COMPARE && w_hit && r_rw) begin
            r_lines[w_index] <= w_merged;
        end else if (r_state == ALLOCATE && mem_data_ready) begin
            r_lines[w_index] <= mem_data;
            r_tags[w_index]  <= w_tag;
        end
    end

    assign cpu_res_ready = r_res_ready;
    assign cpu_res_data  = r_res_data;
    assign hit_count     = r_hit_cnt;
    assign miss_count    = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl_wb_param.sv
// Self-checking bench for cache_ctrl_wb_param: scoreboarded CPU responses,
// a latency-3 memory model with an expected-request queue.
module tb_cache_ctrl_wb_param;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 128;
    localparam int IW = 10;
    localparam int CW = 2;
    localparam int MEM_LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_valid;
    logic          cpu_req_rw;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_data;
    logic [3:0]    cpu_req_be;
    logic          cpu_req_ready;
    logic [DW-1:0] cpu_res_data;
    logic          cpu_res_ready;
    logic          mem_req_valid;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_data;
    logic          mem_data_ready;
    logic [LW-1:0] mem_data;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    always #5 clk = ~clk;

    cache_ctrl_wb_param #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW), .INDEX_W(IW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_req_be(cpu_req_be), .cpu_req_ready(cpu_req_ready),
        .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    typedef struct { bit rd; logic [31:0] data; } res_t;
    typedef struct { bit rw; logic [31:0] addr; logic [127:0] data; } mreq_t;

    res_t  sb[$];
    mreq_t mq[$];
    res_t  sb_e;
    mreq_t mq_e;
    logic [127:0] mem_model [bit [31:0]];
    bit [31:0] ma;
    bit mem_auto = 1'b1;
    int mcnt = 0;

    function automatic logic [127:0] line_init(input logic [31:0] a);
        if (a == 32'h40)
            return 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
        return {a + 32'd3, a + 32'd2, a + 32'd1, a ^ 32'h5A5A_5A5A};
    endfunction

    always @(negedge clk) begin
        if (!rst && cpu_res_ready) begin
            if (sb.size() == 0) begin
                chk("res_unexp", 1, 0);
            end else begin
                sb_e = sb.pop_front();
                if (sb_e.rd) chk("rd_data", cpu_res_data, sb_e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_auto) begin
            if (rst || !mem_req_valid || mem_data_ready) begin
                mem_data_ready = 1'b0;
                mcnt = 0;
            end else if (mcnt == MEM_LAT - 1) begin
                mem_data_ready = 1'b1;
                ma = mem_req_addr;
                if (!mem_model.exists(ma)) mem_model[ma] = line_init(ma);
                if (mem_req_rw) mem_model[ma] = mem_req_data;
                else mem_data = mem_model[ma];
                if (mq.size() == 0) begin
                    chk("mem_unexp", 1, 0);
                end else begin
                    mq_e = mq.pop_front();
                    chk("mem_rw", mem_req_rw, mq_e.rw);
                    chk("mem_addr", mem_req_addr, mq_e.addr);
                    if (mq_e.rw) chk("wb_data", mem_req_data, mq_e.data);
                end
            end else begin
                mcnt++;
            end
        end
    end

    task automatic drive_req(input bit rw, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             input bit push, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = a;
        cpu_req_data  = d;
        cpu_req_be    = be;
        while (!cpu_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) chk("acc_timeout", 0, 1);
        if (push) sb.push_back('{rd: !rw, data: exp});
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
    endtask

    task automatic wait_res(input int exp_lat);
        int lat = 1;
        bit seen = 1'b0;
        while (!seen && lat < 300) begin
            @(posedge clk);
            lat++;
            #1 seen = cpu_res_ready;
        end
        if (!seen) chk("res_timeout", 0, 1);
        else if (exp_lat >= 0) chk("latency", lat, exp_lat);
    endtask

    task automatic cpu_op(input bit rw, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] exp, input int exp_lat);
        drive_req(rw, a, d, be, 1'b1, exp);
        wait_res(exp_lat);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_rw = 1'b0;
        cpu_req_addr = '0;
        cpu_req_data = '0;
        cpu_req_be = '0;
        mem_data_ready = 1'b0;
        mem_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", cpu_req_ready, 1);
        chk("rst_res_ready", cpu_res_ready, 0);
        chk("rst_res_data", cpu_res_data, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        rst = 1'b0;

        mq.push_back('{rw: 1'b0, addr: 32'h40, data: '0});
        cpu_op(1'b0, 32'h44, 0, 0, 32'hBBBB_BBBB, -1);
        chk("cold_miss", miss_count, 1);
        chk("cold_hit", hit_count, 0);

        cpu_op(1'b0, 32'h44, 0, 0, 32'hBBBB_BBBB, 2);
        chk("hit1", hit_count, 1);
        cpu_op(1'b1, 32'h44, 32'h1234_5678, 4'b0011, 0, 2);
        cpu_op(1'b0, 32'h44, 0, 0, 32'hBBBB_5678, 2);
        chk("hit3", hit_count, 3);
        cpu_op(1'b1, 32'h48, 32'hCAFE_F00D, 4'b1100, 0, 2);
        cpu_op(1'b0, 32'h48, 0, 0, 32'hCAFE_CCCC, 2);
        chk("hit_sat", hit_count, 3);
        chk("miss_still1", miss_count, 1);

        mq.push_back('{rw: 1'b1, addr: 32'h40,
            data: 128'hDDDD_DDDD_CAFE_CCCC_BBBB_5678_AAAA_AAAA});
        mq.push_back('{rw: 1'b0, addr: 32'h1_0040, data: '0});
        cpu_op(1'b0, 32'h1_0044, 0, 0, 32'h0001_0041, -1);
        chk("miss2", miss_count, 2);
        mq.push_back('{rw: 1'b0, addr: 32'h40, data: '0});
        cpu_op(1'b0, 32'h44, 0, 0, 32'hBBBB_5678, -1);
        mq.push_back('{rw: 1'b0, addr: 32'h1_0040, data: '0});
        cpu_op(1'b0, 32'h1_0044, 0, 0, 32'h0001_0041, -1);
        chk("miss_sat", miss_count, 3);

        mem_auto = 1'b0;
        mem_data_ready = 1'b0;
        drive_req(1'b0, 32'h44, 0, 0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("alloc_valid", mem_req_valid, 1);
        chk("alloc_rw", mem_req_rw, 0);
        chk("alloc_addr", mem_req_addr, 32'h40);
        mem_data = line_init(32'h40);
        mem_data_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_mem_valid", mem_req_valid, 0);
        chk("mid_rst_req_ready", cpu_req_ready, 1);
        chk("mid_rst_res_data", cpu_res_data, 0);
        repeat (2) @(negedge clk);
        mem_data_ready = 1'b0;
        mem_auto = 1'b1;
        chk("mid_rst_hit", hit_count, 0);
        chk("mid_rst_miss", miss_count, 0);

        mq.push_back('{rw: 1'b0, addr: 32'h40, data: '0});
        cpu_op(1'b0, 32'h44, 0, 0, 32'hBBBB_5678, -1);
        chk("post_rst_miss", miss_count, 1);
        chk("post_rst_hit", hit_count, 0);
        for (int i = 0; i < 5; i++)
            cpu_op(1'b0, 32'h44, 0, 0, 32'hBBBB_5678, 2);
        chk("five_hits_sat", hit_count, 3);

        repeat (3) @(negedge clk);
        chk("sb_left", sb.size(), 0);
        chk("mq_left", mq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
